// File: rtl/serving_arbiter_rr.sv
// rtl/serving_arbiter_rr.sv - N-master to 1-slave Wishbone round-robin arbiter with grant lock and abort
// Optional watchdog: define SERVING_ARB_TIMEOUT_EN to enable the TIMEOUT_CYCLES busy-cycle limit.
module serving_arbiter_rr #(
    parameter int NUM_MASTERS    = 2,
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [NUM_MASTERS*AW-1:0]      i_wb_m_adr,
    input  logic [NUM_MASTERS*DW-1:0]      i_wb_m_dat,
    input  logic [NUM_MASTERS*(DW/8)-1:0]  i_wb_m_sel,
    input  logic [NUM_MASTERS-1:0]         i_wb_m_we,
    input  logic [NUM_MASTERS-1:0]         i_wb_m_stb,
    output logic [DW-1:0]                  o_wb_m_rdt,
    output logic [NUM_MASTERS-1:0]         o_wb_m_ack,
    output logic [AW-1:0]                  o_wb_s_adr,
    output logic [DW-1:0]                  o_wb_s_dat,
    output logic [DW/8-1:0]                o_wb_s_sel,
    output logic                           o_wb_s_we,
    output logic                           o_wb_s_stb,
    input  logic [DW-1:0]                  i_wb_s_rdt,
    input  logic                           i_wb_s_ack,
    output logic [$clog2(NUM_MASTERS)-1:0] o_grant,
    output logic                           o_timeout
);

    localparam int GW = $clog2(NUM_MASTERS);
    localparam int SW = DW / 8;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    if (NUM_MASTERS < 2) begin : g_bad_num_masters
        $error("serving_arbiter_rr: NUM_MASTERS must be >= 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("serving_arbiter_rr: TIMEOUT_CYCLES must be >= 1");
    end
    if ((DW % 8) != 0) begin : g_bad_dw
        $error("serving_arbiter_rr: DW must be a multiple of 8");
    end

    logic [0:0]    state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] pick;
    logic          busy;
    logic          stb_sel;
    logic          timeout;

    assign busy    = (state_q == S_BUSY);
    assign stb_sel = i_wb_m_stb[grant_q];

    // Scan starts one past the last grant, so the last-served master has lowest priority.
    always_comb begin
        int  idx;
        logic found;
        pick  = grant_q;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            idx = (int'(grant_q) + i) % NUM_MASTERS;
            if (!found && i_wb_m_stb[idx]) begin
                pick  = GW'(idx);
                found = 1'b1;
            end
        end
    end

`ifdef SERVING_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // A real ack in the limit cycle wins over the watchdog.
    assign timeout = busy && stb_sel && !i_wb_s_ack &&
                     (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (!busy) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        case (state_q)
            S_IDLE: begin
                if (|i_wb_m_stb) begin
                    state_d = S_BUSY;
                    grant_d = pick;
                end
            end
            default: begin
                if (i_wb_s_ack || timeout || !stb_sel) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            grant_q <= GW'(NUM_MASTERS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    always_comb begin
        o_wb_m_ack = '0;
        if (busy && (i_wb_s_ack || timeout)) begin
            o_wb_m_ack[grant_q] = 1'b1;
        end
    end

    assign o_wb_m_rdt = timeout ? '0 : i_wb_s_rdt;
    assign o_wb_s_stb = busy && stb_sel && !timeout;
    assign o_wb_s_adr = i_wb_m_adr[int'(grant_q)*AW +: AW];
    assign o_wb_s_dat = i_wb_m_dat[int'(grant_q)*DW +: DW];
    assign o_wb_s_sel = i_wb_m_sel[int'(grant_q)*SW +: SW];
    assign o_wb_s_we  = i_wb_m_we[grant_q];
    assign o_grant    = grant_q;
    assign o_timeout  = timeout;

endmodule

// File: tb/tb_serving_arbiter_rr.sv
// tb/tb_serving_arbiter_rr.sv - directed scoreboard bench for serving_arbiter_rr (N=3)
module tb_serving_arbiter_rr;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk;
    logic            rst;
    logic [N*AW-1:0] m_adr;
    logic [N*DW-1:0] m_dat;
    logic [N*4-1:0]  m_sel;
    logic [N-1:0]    m_we;
    logic [N-1:0]    m_stb;
    logic [DW-1:0]   m_rdt;
    logic [N-1:0]    m_ack;
    logic [AW-1:0]   s_adr;
    logic [DW-1:0]   s_dat;
    logic [3:0]      s_sel;
    logic            s_we;
    logic            s_stb;
    logic [DW-1:0]   s_rdt;
    logic            s_ack;
    logic [1:0]      grant;
    logic            tmo;

    int vectors;
    int miscompares;
    int gap;

    typedef struct {
        int          k;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
    } exp_t;

    exp_t sb[$];

    serving_arbiter_rr #(
        .NUM_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT_CYCLES(4)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_wb_m_adr(m_adr), .i_wb_m_dat(m_dat), .i_wb_m_sel(m_sel),
        .i_wb_m_we(m_we), .i_wb_m_stb(m_stb),
        .o_wb_m_rdt(m_rdt), .o_wb_m_ack(m_ack),
        .o_wb_s_adr(s_adr), .o_wb_s_dat(s_dat), .o_wb_s_sel(s_sel),
        .o_wb_s_we(s_we), .o_wb_s_stb(s_stb),
        .i_wb_s_rdt(s_rdt), .i_wb_s_ack(s_ack),
        .o_grant(grant), .o_timeout(tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m(input int k, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic we, input logic stb);
        m_adr[k*AW +: AW] = adr;
        m_dat[k*DW +: DW] = dat;
        m_sel[k*4 +: 4]   = sel;
        m_we[k]           = we;
        m_stb[k]          = stb;
    endtask

    task automatic push(input int k, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic we);
        exp_t e;
        e.k = k; e.adr = adr; e.dat = dat; e.sel = sel; e.we = we;
        sb.push_back(e);
    endtask

    task automatic req(input int k, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic we);
        drive_m(k, adr, dat, sel, we, 1'b1);
        push(k, adr, dat, sel, we);
    endtask

    // Waits for the slave strobe, checks it against the scoreboard, then acks after lat cycles.
    task automatic serve(input int lat, input logic [31:0] rdt, output int g);
        exp_t       e;
        int         n;
        logic [2:0] ea;
        n = 0;
        while (s_stb !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        g = n;
        chk("stb_seen", s_stb, 1);
        chk("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk("grant", grant, e.k);
        chk("s_adr", s_adr, e.adr);
        chk("s_dat", s_dat, e.dat);
        chk("s_sel", s_sel, e.sel);
        chk("s_we", s_we, e.we);
        repeat (lat) begin
            step();
            chk("stb_hold", s_stb, 1);
            chk("ack_wait", m_ack, 0);
        end
        s_ack = 1'b1;
        s_rdt = rdt;
        #1;
        ea = 3'b001 << e.k;
        chk("m_ack", m_ack, ea);
        chk("m_rdt", m_rdt, rdt);
        step();
        s_ack = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst   = 1'b1;
        m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0; m_stb = '0;
        s_rdt = '0; s_ack = 1'b0;
        step();
        step();
        chk("rst_stb", s_stb, 0);
        chk("rst_ack", m_ack, 0);
        chk("rst_grant", grant, 2);
        chk("rst_timeout", tmo, 0);
        rst = 1'b0;

        // single master 1 read
        req(1, 32'h100, 32'h0, 4'hF, 1'b0);
        #1;
        chk("t1_idle_stb", s_stb, 0);
        step();
        chk("t1_latency_stb", s_stb, 1);
        serve(0, 32'hCAFEF00D, gap);
        drive_m(1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        #1;
        chk("t1_grant_after", grant, 1);
        chk("t1_ack_after", m_ack, 0);
        chk("t1_stb_after", s_stb, 0);
        step();

        // all three masters held from reset: rotation 0,1,2,0,1,2
        rst = 1'b1;
        for (int k = 0; k < N; k++) drive_m(k, 32'h1000 + k * 16, 32'hA0 + k, 4'h3, 1'b0, 1'b1);
        step();
        step();
        rst = 1'b0;
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < N; k++) push(k, 32'h1000 + k * 16, 32'hA0 + k, 4'h3, 1'b0);
        for (int t = 0; t < 6; t++) begin
            serve(2, 32'h5000 + t, gap);
            chk("rot_gap", gap, 1);
        end
        m_stb = '0;
        step();

        // m0 write alongside m2 read; m2 served before m0 again
        req(0, 32'h20, 32'h11223344, 4'hF, 1'b1);
        req(2, 32'h300, 32'h0, 4'h1, 1'b0);
        serve(1, 32'h0, gap);
        serve(1, 32'h77, gap);
        m_stb = '0;
        step();

        // m2 aborts; it then loses to m0
        drive_m(2, 32'h340, 32'h0, 4'hF, 1'b0, 1'b1);
        step();
        chk("t4_stb", s_stb, 1);
        chk("t4_grant", grant, 2);
        m_stb[2] = 1'b0;
        #1;
        chk("t4_abort_stb", s_stb, 0);
        chk("t4_abort_ack", m_ack, 0);
        step();
        chk("t4_idle_ack", m_ack, 0);
        chk("t4_grant_kept", grant, 2);
        req(0, 32'h44, 32'h0, 4'hF, 1'b0);
        req(2, 32'h340, 32'h0, 4'hF, 1'b0);
        serve(0, 32'h1, gap);
        m_stb[0] = 1'b0;
        serve(0, 32'h2, gap);
        m_stb = '0;
        step();

        // reset in the middle of a transfer
        drive_m(1, 32'h180, 32'h0, 4'hF, 1'b0, 1'b1);
        step();
        chk("t5_busy_stb", s_stb, 1);
        chk("t5_busy_grant", grant, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("t5_rst_stb", s_stb, 0);
        chk("t5_rst_grant", grant, 2);
        chk("t5_rst_ack", m_ack, 0);
        req(0, 32'h80, 32'h0, 4'hF, 1'b0);
        push(1, 32'h180, 32'h0, 4'hF, 1'b0);
        serve(0, 32'h3, gap);
        m_stb[0] = 1'b0;
        serve(0, 32'h4, gap);
        m_stb = '0;
        step();

        // slave never acks
        drive_m(2, 32'h3C0, 32'h0, 4'hF, 1'b0, 1'b1);
        s_rdt = 32'hDEADBEEF;
        step();
`ifdef SERVING_ARB_TIMEOUT_EN
        for (int c = 1; c < 4; c++) begin
            chk("wd_stb", s_stb, 1);
            chk("wd_pre_timeout", tmo, 0);
            chk("wd_pre_ack", m_ack, 0);
            step();
        end
        chk("wd_timeout", tmo, 1);
        chk("wd_ack", m_ack, 3'b100);
        chk("wd_rdt", m_rdt, 0);
        chk("wd_stb_low", s_stb, 0);
        m_stb = '0;
        step();
        chk("wd_timeout_pulse", tmo, 0);
        chk("wd_ack_after", m_ack, 0);
`else
        for (int c = 0; c < 10; c++) begin
            chk("hang_stb", s_stb, 1);
            chk("hang_ack", m_ack, 0);
            chk("hang_timeout", tmo, 0);
            step();
        end
        m_stb = '0;
        #1;
        chk("hang_abort_stb", s_stb, 0);
        step();
`endif
        chk("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
